regfile_write_arbiter: RTL

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter.sv | 80 ++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - two-requester register file write arbiter with optional zero-fill after reset
module regfile_write_arbiter #(
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic        clock,
  input  logic        Reset,
  input  logic        ReqA,
  input  logic [4:0]  RegA,
  input  logic [31:0] DataA,
  output logic        GntA,
  input  logic        ReqB,
  input  logic [4:0]  RegB,
  input  logic [31:0] DataB,
  output logic        GntB,
  output logic [4:0]  WriteReg,
  output logic [31:0] WriteData,
  output logic        RegWrite,
  output logic        Busy
);

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;
  localparam logic       FILL    = (CLEAR_ON_RESET != 0);

  logic [0:0]  state;
  logic [4:0]  counter;
  logic        ptr;        // 0 = A wins the next contended cycle, 1 = B
  logic [4:0]  wreg_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic        clearing;
  logic        running;

  assign clearing = !Reset && (state == S_CLEAR);
  assign running  = !Reset && (state == S_RUN);

  assign GntA = running && ReqA && (!ReqB || !ptr);
  assign GntB = running && ReqB && (!ReqA || ptr);
  assign Busy = Reset ? FILL : (state == S_CLEAR);

  // The fill drives the write port straight from the counter so that
  // register 0 is written in the very first cycle after reset.
  assign WriteReg  = clearing ? counter : wreg_q;
  assign WriteData = clearing ? 32'd0   : wdata_q;
  assign RegWrite  = clearing ? 1'b1    : we_q;

  always_ff @(posedge clock) begin
    if (Reset) begin
      state   <= FILL ? S_CLEAR : S_RUN;
      counter <= 5'd0;
      ptr     <= 1'b0;
      wreg_q  <= 5'd0;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
    end else if (state == S_CLEAR) begin
      counter <= counter + 5'd1;
      we_q    <= 1'b0;
      if (counter == 5'd31) begin
        state <= S_RUN;
      end
    end else begin
      if (GntA) begin
        wreg_q  <= RegA;
        wdata_q <= DataA;
        we_q    <= (RegA != 5'd0);
      end else if (GntB) begin
        wreg_q  <= RegB;
        wdata_q <= DataB;
        we_q    <= (RegB != 5'd0);
      end else begin
        we_q    <= 1'b0;
      end
      // Contention always produces a grant to ptr, so the loser is ~ptr.
      if (ReqA && ReqB) begin
        ptr <= ~ptr;
      end
    end
  end

endmodule
